// File: rtl/cfu_pkg.sv
// Shared CFU definitions: command codes, FSM states and
// 32-bit limits used by the requantization stage.
package cfu_pkg;

  localparam int CH_W = 7;

  localparam logic [6:0] CMD_CLEAR  = 7'd0;
  localparam logic [6:0] CMD_BIAS   = 7'd30;
  localparam logic [6:0] CMD_MULT   = 7'd31;
  localparam logic [6:0] CMD_SHIFT  = 7'd32;
  localparam logic [6:0] CMD_OFFSET = 7'd33;
  localparam logic [6:0] CMD_ACT    = 7'd34;
  localparam logic [6:0] CMD_REQ    = 7'd50;
  localparam logic [6:0] CMD_LAST   = 7'd51;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_BUSY
  } state_t;

endpackage

// File: rtl/requant_pipe.sv
// Five-stage requant datapath: bias/shift, multiply, rounding
// doubling-high-mul, rounding right shift, offset and clamp.
module requant_pipe
  import cfu_pkg::*;
#(
  parameter int BYTE_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CH_W-1:0]        in_ch,
  input  logic signed [31:0]     in_acc,
  output logic [CH_W-1:0]        ch,
  input  logic signed [31:0]     bias,
  input  logic signed [31:0]     mult,
  input  logic signed [5:0]      shift,
  input  logic signed [31:0]     offset,
  input  logic signed [31:0]     act_min,
  input  logic signed [31:0]     act_max,
  output logic                   out_valid,
  output logic [31:0]            result
);

  logic [4:0] v;
  logic signed [31:0] acc0;
  logic signed [31:0] x1, m1;
  logic [5:0] rs1, rs2, rs3;
  logic signed [63:0] p2;
  logic sat2;
  logic signed [31:0] y3, z4;

  logic signed [31:0] sum1, x1_d;
  logic [5:0] ls, rs;
  logic signed [63:0] s3, q3;
  logic signed [31:0] y3_d;
  logic signed [63:0] y64, sh64;
  logic [63:0] mask, rem, thr;
  logic signed [31:0] z4_d;
  logic signed [31:0] o5, lo5, hi5;

  assign sum1 = acc0 + bias;
  assign ls   = shift[5] ? 6'd0 : $unsigned(shift);
  assign rs   = shift[5] ? $unsigned(-shift) : 6'd0;
  assign x1_d = sum1 << ls;

  // Nudge then divide by 2^31 truncating toward zero.
  assign s3   = p2 + (p2[63] ? -64'sd1073741823
                             : 64'sd1073741824);
  assign q3   = s3 >>> 31;
  assign y3_d = sat2 ? INT32_MAX
              : q3[31:0] + {31'd0, s3[63] && (|s3[30:0])};

  // 64-bit so that a shift of 32 keeps a full mask.
  assign y64  = {{32{y3[31]}}, y3};
  assign mask = (64'd1 << rs3) - 64'd1;
  assign rem  = y64 & mask;
  assign thr  = (mask >> 1) + {63'd0, y3[31]};
  assign sh64 = y64 >>> rs3;
  assign z4_d = sh64[31:0] + {31'd0, rem > thr};

  assign o5  = z4 + offset;
  assign lo5 = (o5 < act_min) ? act_min : o5;
  assign hi5 = (lo5 > act_max) ? act_max : lo5;

  assign result    = {{(32-BYTE_SIZE){hi5[BYTE_SIZE-1]}},
                      hi5[BYTE_SIZE-1:0]};
  assign out_valid = v[4];

  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else     v <= {v[3:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      acc0 <= in_acc;
      ch   <= in_ch;
    end
    x1   <= x1_d;
    m1   <= mult;
    rs1  <= rs;
    p2   <= 64'(x1) * 64'(m1);
    sat2 <= (x1 == INT32_MIN) && (m1 == INT32_MIN);
    rs2  <= rs1;
    y3   <= y3_d;
    rs3  <= rs2;
    z4   <= z4_d;
  end

endmodule

// File: rtl/conv1d_requant.sv
// Requantization CFU: per-channel tables, scalars, command
// decode and FSM around the requant_pipe datapath.
module conv1d_requant
  import cfu_pkg::*;
#(
  parameter int INT32_SIZE          = 32,
  parameter int BYTE_SIZE           = 8,
  parameter int MAX_OUTPUT_CHANNELS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid
);

  state_t state, state_d;
  logic [CH_W-1:0] clr_idx;

  logic signed [31:0] bias_t  [MAX_OUTPUT_CHANNELS];
  logic signed [31:0] mult_t  [MAX_OUTPUT_CHANNELS];
  logic signed [5:0]  shift_t [MAX_OUTPUT_CHANNELS];

  logic signed [31:0] output_offset, act_min, act_max;

  logic idle, acc_ok, req;
  logic [CH_W-1:0] ch, pipe_ch;
  logic pipe_valid;
  logic [31:0] pipe_res;

  assign ch     = inp0[CH_W-1:0];
  assign idle   = (state == ST_IDLE);
  assign acc_ok = en && idle && !rst;
  assign req    = acc_ok && (cmd == CMD_REQ);

  assign output_buffer_valid = idle;

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (en) begin
        unique case (1'b1)
          cmd == CMD_CLEAR: state_d = ST_CLEAR;
          cmd == CMD_REQ:   state_d = ST_BUSY;
          cmd == CMD_LAST:  state_d = ST_IDLE;
          default: ;
        endcase
      end
      ST_CLEAR: if (clr_idx == '1) state_d = ST_IDLE;
      ST_BUSY:  if (pipe_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_CLEAR;
      clr_idx       <= '0;
      ret           <= '0;
      output_offset <= '0;
      act_min       <= -32'sd128;
      act_max       <= 32'sd127;
    end else begin
      state   <= state_d;
      clr_idx <= (state == ST_CLEAR) ? clr_idx + 1'b1 : '0;
      if (pipe_valid) ret <= pipe_res;
      if (acc_ok && cmd == CMD_OFFSET) output_offset <= inp1;
      if (acc_ok && cmd == CMD_ACT) begin
        act_min <= inp0;
        act_max <= inp1;
      end
    end
  end

  // Tables carry no reset; the CLEAR walk zeroes them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        bias_t[clr_idx]  <= '0;
        mult_t[clr_idx]  <= '0;
        shift_t[clr_idx] <= '0;
      end else if (acc_ok) begin
        case (cmd)
          CMD_BIAS:  bias_t[ch]  <= inp1;
          CMD_MULT:  mult_t[ch]  <= inp1;
          CMD_SHIFT: shift_t[ch] <= inp1[5:0];
          default: ;
        endcase
      end
    end
  end

  requant_pipe #(
    .BYTE_SIZE(BYTE_SIZE)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (req),
    .in_ch    (ch),
    .in_acc   (inp1),
    .ch       (pipe_ch),
    .bias     (bias_t[pipe_ch]),
    .mult     (mult_t[pipe_ch]),
    .shift    (shift_t[pipe_ch]),
    .offset   (output_offset),
    .act_min  (act_min),
    .act_max  (act_max),
    .out_valid(pipe_valid),
    .result   (pipe_res)
  );

endmodule

// File: tb/tb_conv1d_requant.sv
// Bench for conv1d_requant: vector table plus hand sequences
// for dropped writes, mid-flight reset and table clear.
module tb_conv1d_requant;

  logic clk = 1'b0;
  logic rst, en;
  logic [6:0] cmd;
  logic [31:0] inp0, inp1, ret;
  logic obv;

  always #5 clk = ~clk;

  conv1d_requant dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .cmd                (cmd),
    .inp0               (inp0),
    .inp1               (inp1),
    .ret                (ret),
    .output_buffer_valid(obv)
  );

  typedef struct {
    int          ch;
    logic [31:0] bias;
    logic [31:0] mult;
    int          shift;
    logic [31:0] off;
    logic [31:0] amin;
    logic [31:0] amax;
    logic [31:0] acc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [6:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b);
    en = 1'b1; cmd = c; inp0 = a; inp1 = b;
    @(posedge clk); #1;
    en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!obv && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic request(input int ch,
                         input logic [31:0] acc,
                         input logic [31:0] exp);
    sb.push_back(exp);
    issue(7'd50, ch, acc);
  endtask

  task automatic collect(input string nm, input int lat);
    int n;
    logic [31:0] e;
    wait_valid(n);
    check({nm, " latency"}, n, lat);
    e = sb.pop_front();
    check(nm, ret, e);
  endtask

  task automatic setup(input vec_t v);
    issue(7'd30, v.ch, v.bias);
    issue(7'd31, v.ch, v.mult);
    issue(7'd32, v.ch, v.shift);
    issue(7'd33, 0, v.off);
    issue(7'd34, v.amin, v.amax);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0;

    vecs[0] = '{3, 24, 32'h4000_0000, -3, -5, -128, 127,
                1000, 32'h0000_003B};
    vecs[1] = '{3, 24, 32'h4000_0000, -3, -5, -128, 127,
                -1000, 32'hFFFF_FFBE};
    vecs[2] = '{10, 0, 32'h7FFF_FFFF, -3, 0, -128, 127,
                -12, 32'hFFFF_FFFE};
    vecs[3] = '{10, 0, 32'h7FFF_FFFF, -3, 0, -128, 127,
                12, 32'h0000_0002};
    vecs[4] = '{127, 0, 32'h8000_0000, 0, 0, -128, 127,
                32'h8000_0000, 32'h0000_007F};
    vecs[5] = '{0, 0, 32'h4000_0000, 0, 0, -128, 127,
                -1000, 32'hFFFF_FF80};
    vecs[6] = '{5, 0, 32'h4000_0000, 2, 0, -1000, 1000,
                100, 32'hFFFF_FFC8};
    vecs[7] = '{6, 0, 0, 0, 0, 50, 10,
                0, 32'h0000_000A};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset ret", ret, 32'd0);
    check("reset valid", obv, 1'b0);
    wait_valid(n);
    check("reset clear length", n, 128);

    issue(7'd51, 0, 0);
    check("cmd51 ret", ret, 32'd0);
    check("cmd51 valid", obv, 1'b1);

    for (int i = 0; i < 8; i++) begin
      setup(vecs[i]);
      check($sformatf("vec%0d write valid", i), obv, 1'b1);
      request(vecs[i].ch, vecs[i].acc, vecs[i].exp);
      collect($sformatf("vec%0d", i), 5);
    end

    issue(7'd51, 0, 0);
    check("cmd51 hold ret", ret, vecs[7].exp);
    check("cmd51 hold valid", obv, 1'b1);

    setup(vecs[0]);
    request(3, 1000, 32'h0000_003B);
    @(posedge clk); #1;
    issue(7'd30, 3, 1000);
    collect("drop first", 3);
    request(3, 1000, 32'h0000_003B);
    collect("drop reread", 5);

    issue(7'd50, 3, 1000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset ret", ret, 32'd0);
    check("midreset valid", obv, 1'b0);
    wait_valid(n);
    check("midreset clear length", n, 128);
    check("midreset no result", ret, 32'd0);
    issue(7'd31, 3, 32'h7FFF_FFFF);
    request(3, 7, 32'd7);
    collect("after reset clear", 5);

    issue(7'd30, 3, 24);
    issue(7'd0, 0, 0);
    check("cmd0 valid", obv, 1'b0);
    wait_valid(n);
    check("cmd0 clear length", n, 128);
    issue(7'd31, 3, 32'h7FFF_FFFF);
    request(3, 7, 32'd7);
    collect("after cmd0 clear", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
